// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: opcode/funct
// codes, ALU control encoding, mux select encodings, the FSM state type and
// the per-state Moore control decode.
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

    typedef enum logic [3:0] {
        S_RST, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXEC, S_RWB, S_IEXEC, S_IWB, S_BRANCH, S_JUMP, S_HALT
    } state_t;

    // Which ALU function family a state needs.
    typedef enum logic [2:0] {
        CLS_ZERO, CLS_ADD, CLS_SUB, CLS_RTYPE, CLS_ITYPE
    } alu_class_t;

    // Moore part of the control word. The three pc/ir write qualifiers are
    // combined with mem_ready / zero outside the register.
    typedef struct packed {
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       ext_sel;
        logic       pc_wr_always;
        logic       fetch_wr;
        logic       pc_wr_zero;
    } ctrl_t;

    function automatic ctrl_t ctrl_decode(input state_t s, input logic [5:0] op);
        ctrl_t c;
        c = '0;
        c.ext_sel = 1'b1;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.pc_src    = PCSRC_ALU;
                c.fetch_wr  = 1'b1;
            end
            S_DECODE: c.alu_src_b = SRCB_IMM_SH2;
            S_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            S_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_RT;
            end
            S_RWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_IEXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.ext_sel   = !(op == OP_ANDI || op == OP_ORI);
            end
            // Logical immediates keep zero extension through write-back.
            S_IWB: begin
                c.reg_write = 1'b1;
                c.ext_sel   = !(op == OP_ANDI || op == OP_ORI);
            end
            S_BRANCH: begin
                c.alu_src_a  = 1'b1;
                c.alu_src_b  = SRCB_RT;
                c.pc_src     = PCSRC_ALUOUT;
                c.pc_wr_zero = 1'b1;
            end
            S_JUMP: begin
                c.pc_wr_always = 1'b1;
                c.pc_src       = PCSRC_JUMP;
            end
            default: ;
        endcase
        return c;
    endfunction

    function automatic alu_class_t alu_class(input state_t s);
        case (s)
            S_FETCH, S_DECODE, S_MEMADR: return CLS_ADD;
            S_BRANCH:                    return CLS_SUB;
            S_EXEC:                      return CLS_RTYPE;
            S_IEXEC:                     return CLS_ITYPE;
            default:                     return CLS_ZERO;
        endcase
    endfunction

    // States that wait on the memory handshake and are timeout-guarded.
    function automatic logic is_mem_wait(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// ALU control decoder (combinational).
// Ports: i_class - ALU function family of the state being entered,
//        i_opcode / i_funct - instruction fields,
//        o_alu_ctrl - ALU function code, o_funct_valid - funct is supported.
module alu_decoder
    import mc_pkg::*;
(
    input  alu_class_t  i_class,
    input  logic [5:0]  i_opcode,
    input  logic [5:0]  i_funct,
    output logic [2:0]  o_alu_ctrl,
    output logic        o_funct_valid
);

    logic [2:0] w_funct_ctrl;

    // Depends on funct only, so the FSM can use o_funct_valid for its own
    // next-state choice without a combinational loop through i_class.
    always_comb begin
        w_funct_ctrl  = ALU_ADD;
        o_funct_valid = 1'b1;
        case (i_funct)
            FN_ADD:  w_funct_ctrl = ALU_ADD;
            FN_SUB:  w_funct_ctrl = ALU_SUB;
            FN_AND:  w_funct_ctrl = ALU_AND;
            FN_OR:   w_funct_ctrl = ALU_OR;
            FN_SLT:  w_funct_ctrl = ALU_SLT;
            default: o_funct_valid = 1'b0;
        endcase
    end

    always_comb begin
        o_alu_ctrl = 3'b000;
        case (i_class)
            CLS_ADD:   o_alu_ctrl = ALU_ADD;
            CLS_SUB:   o_alu_ctrl = ALU_SUB;
            CLS_RTYPE: o_alu_ctrl = w_funct_ctrl;
            CLS_ITYPE: begin
                case (i_opcode)
                    OP_ANDI: o_alu_ctrl = ALU_AND;
                    OP_ORI:  o_alu_ctrl = ALU_OR;
                    default: o_alu_ctrl = ALU_ADD;
                endcase
            end
            default: o_alu_ctrl = 3'b000;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM. Drives datapath selects and write enables,
// stalls on mem_ready, traps on illegal instructions / memory timeouts and
// counts retired instructions.
// Ports: clk, rst_n (async, active low); opcode, funct, zero, mem_ready in;
//        datapath controls, sticky trap code and retired counter out.
module multicycle_control
    import mc_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_ctrl,
    output logic [1:0]       pc_src,
    output logic             ext_sel,
    output logic [1:0]       trap,
    output logic [CNT_W-1:0] retired
);

    state_t           r_state, w_state_next;
    ctrl_t            r_ctrl;
    logic [2:0]       r_alu_ctrl, w_alu_ctrl;
    logic [1:0]       r_trap, w_trap_next;
    logic [7:0]       r_wait_cnt;
    logic [CNT_W-1:0] r_retired;
    alu_class_t       w_next_class;
    logic             w_funct_valid, w_limit, w_retire;

    assign w_next_class = alu_class(w_state_next);

    alu_decoder u_alu_decoder (
        .i_class       (w_next_class),
        .i_opcode      (opcode),
        .i_funct       (funct),
        .o_alu_ctrl    (w_alu_ctrl),
        .o_funct_valid (w_funct_valid)
    );

    // This is the TIMEOUT-th consecutive stall cycle; a ready in this very
    // cycle still advances normally.
    assign w_limit = (r_wait_cnt == 8'(TIMEOUT - 1)) && !mem_ready;

    assign w_retire = (r_state == S_MEMWB) || (r_state == S_RWB) ||
                      (r_state == S_IWB)   || (r_state == S_BRANCH) ||
                      (r_state == S_JUMP)  || (r_state == S_MEMWR && mem_ready);

    always_comb begin
        w_state_next = r_state;
        w_trap_next  = r_trap;
        case (r_state)
            S_RST:   w_state_next = S_FETCH;
            S_FETCH, S_MEMRD, S_MEMWR: begin
                if (mem_ready) begin
                    case (r_state)
                        S_FETCH: w_state_next = S_DECODE;
                        S_MEMRD: w_state_next = S_MEMWB;
                        default: w_state_next = S_FETCH;
                    endcase
                end else if (w_limit) begin
                    w_state_next = S_HALT;
                    w_trap_next  = TRAP_TIMEOUT;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:              w_state_next = S_MEMADR;
                    OP_RTYPE:                  w_state_next = S_EXEC;
                    OP_BEQ:                    w_state_next = S_BRANCH;
                    OP_J:                      w_state_next = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI:  w_state_next = S_IEXEC;
                    default: begin
                        w_state_next = S_HALT;
                        w_trap_next  = TRAP_ILLEGAL;
                    end
                endcase
            end
            S_MEMADR: w_state_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_EXEC: begin
                if (w_funct_valid) begin
                    w_state_next = S_RWB;
                end else begin
                    w_state_next = S_HALT;
                    w_trap_next  = TRAP_ILLEGAL;
                end
            end
            S_IEXEC: w_state_next = S_IWB;
            S_MEMWB, S_RWB, S_IWB, S_BRANCH, S_JUMP: w_state_next = S_FETCH;
            S_HALT:  w_state_next = S_HALT;
            default: w_state_next = S_RST;
        endcase
    end

    // Outputs are registered from the state being entered, so they are a
    // clean Moore decode of r_state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_RST;
            r_ctrl     <= ctrl_decode(S_RST, 6'd0);
            r_alu_ctrl <= 3'b000;
            r_trap     <= TRAP_NONE;
            r_wait_cnt <= '0;
            r_retired  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_ctrl     <= ctrl_decode(w_state_next, opcode);
            r_alu_ctrl <= w_alu_ctrl;
            r_trap     <= w_trap_next;
            // Any cycle that is not a stall (including the entry cycle of a
            // wait state) starts the count from zero.
            if (is_mem_wait(r_state) && !mem_ready) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end else begin
                r_wait_cnt <= '0;
            end
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    assign pc_write   = r_ctrl.pc_wr_always | (r_ctrl.fetch_wr & mem_ready) |
                        (r_ctrl.pc_wr_zero & zero);
    assign ir_write   = r_ctrl.fetch_wr & mem_ready;
    assign iord       = r_ctrl.iord;
    assign mem_read   = r_ctrl.mem_read;
    assign mem_write  = r_ctrl.mem_write;
    assign reg_write  = r_ctrl.reg_write;
    assign reg_dst    = r_ctrl.reg_dst;
    assign mem_to_reg = r_ctrl.mem_to_reg;
    assign alu_src_a  = r_ctrl.alu_src_a;
    assign alu_src_b  = r_ctrl.alu_src_b;
    assign alu_ctrl   = r_alu_ctrl;
    assign pc_src     = r_ctrl.pc_src;
    assign ext_sel    = r_ctrl.ext_sel;
    assign trap       = r_trap;
    assign retired    = r_retired;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    localparam int TB_TIMEOUT = 15;
    localparam int TB_CNT_W   = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  opcode, funct;
    logic        zero, mem_ready;
    logic        pc_write, ir_write, iord, mem_read, mem_write, reg_write;
    logic        reg_dst, mem_to_reg, alu_src_a, ext_sel;
    logic [1:0]  alu_src_b, pc_src, trap;
    logic [2:0]  alu_ctrl;
    logic [TB_CNT_W-1:0] retired;

    always #5 clk = ~clk;

    multicycle_control #(.TIMEOUT(TB_TIMEOUT), .CNT_W(TB_CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
        .pc_src(pc_src), .ext_sel(ext_sel), .trap(trap), .retired(retired)
    );

    // Instruction phases as named by the sequencer description.
    typedef enum {P_RST, P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR,
                  P_EXEC, P_RWB, P_IEXEC, P_IWB, P_BRANCH, P_JUMP, P_HALT} phase_e;

    int          checks = 0;
    int          errors = 0;
    logic [1:0]  model_trap;
    logic [31:0] model_retired;

    function automatic logic funct_ok(input logic [5:0] fn);
        return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    endfunction

    function automatic logic [2:0] rtype_alu(input logic [5:0] fn);
        case (fn)
            6'h22:   return 3'b110;
            6'h24:   return 3'b000;
            6'h25:   return 3'b001;
            6'h2A:   return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    // Expected control word:
    // {pc_write, ir_write, iord, mem_read, mem_write, reg_write, reg_dst,
    //  mem_to_reg, alu_src_a, alu_src_b[1:0], alu_ctrl[2:0], pc_src[1:0], ext_sel}
    function automatic logic [16:0] exp_vec(input phase_e ph, input logic [5:0] op,
                                            input logic [5:0] fn, input logic z,
                                            input logic rdy);
        logic pcw, irw, io, mrd, mwr, rw, rd, m2r, sa, es;
        logic [1:0] sb, ps;
        logic [2:0] ac;
        logic logical_imm;
        {pcw, irw, io, mrd, mwr, rw, rd, m2r, sa} = '0;
        sb = 2'b00; ps = 2'b00; ac = 3'b000; es = 1'b1;
        logical_imm = (op == 6'h0C) || (op == 6'h0D);
        case (ph)
            P_FETCH:  begin mrd = 1; sb = 2'b01; ac = 3'b010; pcw = rdy; irw = rdy; end
            P_DECODE: begin sb = 2'b11; ac = 3'b010; end
            P_MEMADR: begin sa = 1; sb = 2'b10; ac = 3'b010; end
            P_MEMRD:  begin mrd = 1; io = 1; end
            P_MEMWB:  begin rw = 1; m2r = 1; end
            P_MEMWR:  begin mwr = 1; io = 1; end
            P_EXEC:   begin sa = 1; sb = 2'b00; ac = rtype_alu(fn); end
            P_RWB:    begin rw = 1; rd = 1; end
            P_IEXEC:  begin
                sa = 1; sb = 2'b10;
                ac = (op == 6'h0C) ? 3'b000 : (op == 6'h0D) ? 3'b001 : 3'b010;
                es = !logical_imm;
            end
            P_IWB:    begin rw = 1; es = !logical_imm; end
            P_BRANCH: begin sa = 1; sb = 2'b00; ac = 3'b110; ps = 2'b01; pcw = z; end
            P_JUMP:   begin pcw = 1; ps = 2'b10; end
            default:  ;
        endcase
        return {pcw, irw, io, mrd, mwr, rw, rd, m2r, sa, sb, ac, ps, es};
    endfunction

    function automatic logic [16:0] dut_vec();
        return {pc_write, ir_write, iord, mem_read, mem_write, reg_write, reg_dst,
                mem_to_reg, alu_src_a, alu_src_b, alu_ctrl, pc_src, ext_sel};
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // One clock cycle: drive inputs just after a falling edge, compare #1
    // later, then advance to the next falling edge.
    task automatic cycle(input phase_e ph, input logic rdy, input logic z,
                         input logic retire, input string tag);
        logic [16:0] e, a, m;
        mem_ready = rdy;
        zero      = z;
        #1;
        e = exp_vec(ph, opcode, funct, z, rdy);
        a = dut_vec();
        // The ALU function for an unsupported funct is left open.
        m = (ph == P_EXEC && !funct_ok(funct)) ? 17'h1FFC7 : 17'h1FFFF;
        checks++;
        if ((a & m) !== (e & m)) begin
            errors++;
            $display("FAIL %s ctrl phase=%s got=%05h exp=%05h", tag, ph.name(), a, e);
        end
        checks++;
        if (trap !== model_trap) begin
            errors++;
            $display("FAIL %s trap phase=%s got=%0d exp=%0d", tag, ph.name(), trap, model_trap);
        end
        checks++;
        if (retired !== model_retired) begin
            errors++;
            $display("FAIL %s retired phase=%s got=%0d exp=%0d", tag, ph.name(), retired, model_retired);
        end
        if (retire) model_retired++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; opcode = 6'h00; funct = 6'h00;
        model_retired = 0;
        model_trap    = 2'b00;
        repeat (2) @(negedge clk);
        cycle(P_RST, rnd_bit(), rnd_bit(), 1'b0, "reset_held");
        rst_n = 1'b1;
        cycle(P_RST, rnd_bit(), rnd_bit(), 1'b0, "reset_release");
    endtask

    task automatic halt_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(P_HALT, rnd_bit(), rnd_bit(), 1'b0, "halt");
    endtask

    // Instruction-level reference: expected phase sequence for one instruction.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int wf, input int wm);
        opcode = op; funct = fn;
        for (int i = 0; i < wf; i++) cycle(P_FETCH, 1'b0, z, 1'b0, "fetch_wait");
        cycle(P_FETCH, 1'b1, z, 1'b0, "fetch");
        cycle(P_DECODE, rnd_bit(), z, 1'b0, "decode");
        case (op)
            6'h23: begin
                cycle(P_MEMADR, rnd_bit(), z, 1'b0, "lw_adr");
                for (int i = 0; i < wm; i++) cycle(P_MEMRD, 1'b0, z, 1'b0, "lw_wait");
                cycle(P_MEMRD, 1'b1, z, 1'b0, "lw_rd");
                cycle(P_MEMWB, rnd_bit(), z, 1'b1, "lw_wb");
            end
            6'h2B: begin
                cycle(P_MEMADR, rnd_bit(), z, 1'b0, "sw_adr");
                for (int i = 0; i < wm; i++) cycle(P_MEMWR, 1'b0, z, 1'b0, "sw_wait");
                cycle(P_MEMWR, 1'b1, z, 1'b1, "sw_wr");
            end
            6'h00: begin
                cycle(P_EXEC, rnd_bit(), z, 1'b0, "r_exec");
                if (funct_ok(fn)) cycle(P_RWB, rnd_bit(), z, 1'b1, "r_wb");
                else model_trap = 2'b01;
            end
            6'h04: cycle(P_BRANCH, rnd_bit(), z, 1'b1, "beq");
            6'h02: cycle(P_JUMP, rnd_bit(), z, 1'b1, "jump");
            6'h08, 6'h0C, 6'h0D: begin
                cycle(P_IEXEC, rnd_bit(), z, 1'b0, "i_exec");
                cycle(P_IWB, rnd_bit(), z, 1'b1, "i_wb");
            end
            default: model_trap = 2'b01;
        endcase
        $display("INSTR op=%02h fn=%02h zero=%0d waits=%0d/%0d trap=%0d retired_model=%0d",
                 op, fn, z, wf, wm, model_trap, model_retired);
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_rtype_add();
        run_instr(6'h00, 6'h20, 1'b0, 0, 0);
        #1;
        checks++;
        if (retired !== 32'd1) begin
            errors++;
            $display("FAIL add_retired got=%0d exp=1", retired);
        end
        #1;
    endtask

    task automatic test_lw_wait();
        run_instr(6'h23, 6'h00, 1'b0, 0, 3);
    endtask

    task automatic test_beq();
        run_instr(6'h04, 6'h00, 1'b1, 0, 0);
        run_instr(6'h04, 6'h00, 1'b0, 0, 0);
    endtask

    task automatic test_itype();
        run_instr(6'h0C, 6'h00, 1'b0, 0, 0);
        run_instr(6'h08, 6'h00, 1'b0, 0, 0);
        run_instr(6'h0D, 6'h00, 1'b0, 1, 0);
    endtask

    task automatic test_illegal();
        run_instr(6'h3F, 6'h00, 1'b0, 0, 0);
        halt_cycles(4);
        do_reset();
        run_instr(6'h00, 6'h20, 1'b0, 0, 0);
        run_instr(6'h00, 6'h00, 1'b0, 0, 0);
        halt_cycles(4);
        do_reset();
    endtask

    task automatic test_timeout();
        // One short of the limit still completes normally.
        run_instr(6'h00, 6'h22, 1'b0, TB_TIMEOUT - 1, 0);
        run_instr(6'h2B, 6'h00, 1'b0, 0, TB_TIMEOUT - 1);
        opcode = 6'h00; funct = 6'h20;
        for (int i = 0; i < TB_TIMEOUT; i++) cycle(P_FETCH, 1'b0, 1'b0, 1'b0, "fetch_stall");
        model_trap = 2'b10;
        halt_cycles(3);
        do_reset();
    endtask

    task automatic test_reset_mid_memwr();
        run_instr(6'h02, 6'h00, 1'b0, 0, 0);
        opcode = 6'h2B; funct = 6'h00;
        cycle(P_FETCH, 1'b1, 1'b0, 1'b0, "fetch");
        cycle(P_DECODE, 1'b0, 1'b0, 1'b0, "decode");
        cycle(P_MEMADR, 1'b0, 1'b0, 1'b0, "sw_adr");
        mem_ready = 1'b0;
        #1;
        checks++;
        if (mem_write !== 1'b1) begin
            errors++;
            $display("FAIL memwr_before_reset mem_write got=%0b exp=1", mem_write);
        end
        rst_n = 1'b0;
        model_retired = 0;
        model_trap    = 2'b00;
        #1;
        checks++;
        if (dut_vec() !== exp_vec(P_RST, opcode, funct, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL async_reset ctrl got=%05h exp=%05h", dut_vec(),
                     exp_vec(P_RST, opcode, funct, 1'b0, 1'b0));
        end
        checks++;
        if (retired !== model_retired) begin
            errors++;
            $display("FAIL async_reset retired got=%0d exp=%0d", retired, model_retired);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cycle(P_RST, 1'b0, 1'b0, 1'b0, "reset_release");
        run_instr(6'h2B, 6'h00, 1'b0, 0, 1);
    endtask

    task automatic test_random();
        logic [5:0] ops [8];
        logic [5:0] fns [5];
        logic [5:0] op, fn;
        ops = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h02, 6'h08, 6'h0C, 6'h0D};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        for (int n = 0; n < 40; n++) begin
            op = ops[$urandom_range(0, 7)];
            fn = fns[$urandom_range(0, 4)];
            run_instr(op, fn, rnd_bit(), $urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

    initial begin
        rst_n = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
        model_trap = 2'b00; model_retired = 0;
        test_reset();
        test_rtype_add();
        test_lw_wait();
        test_beq();
        test_itype();
        test_illegal();
        test_timeout();
        test_reset_mid_memwr();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle sequencer for the MIPS datapath: one ALU, one unified memory, register file and immediate extender are shared across cycles under FSM control.
- Decodes opcode/funct and drives every datapath select and write enable.
- Selects sign vs zero extension of the 16-bit immediate.
- Stalls on a memory ready handshake, traps on illegal opcodes and memory timeouts, and counts retired instructions.

Parameters:
TIMEOUT, 15, max cycles a memory state waits for mem_ready before trapping (1..255)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes access this cycle
pc_write  out  1  PC load enable
ir_write  out  1  IR load enable
iord  out  1  memory address: 0=PC, 1=ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
reg_write  out  1  register file write enable
reg_dst  out  1  write reg: 0=rt, 1=rd
mem_to_reg  out  1  write data: 0=ALUOut, 1=MDR
alu_src_a  out  1  0=PC, 1=rs
alu_src_b  out  2  00=rt, 01=const 4, 10=ext imm, 11=ext imm<<2
alu_ctrl  out  3  ALU function (package encoding)
pc_src  out  2  00=ALU, 01=ALUOut, 10=jump target
ext_sel  out  1  extender mode: 1=sign, 0=zero
trap  out  2  00=none, 01=illegal opcode, 10=memory timeout; sticky
retired  out  CNT_W  instructions completed since reset

Behaviour:
- States: RST, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, RWB, IEXEC, IWB, BRANCH, JUMP, HALT.
- rst_n low (any cycle, including mid-instruction) -> state=RST, retired=0, trap=00, timeout counter=0.
- In RST all outputs are 0 except ext_sel=1. RST -> FETCH unconditionally on the next edge.
- All outputs are Moore decodes of state, except pc_write (gated by mem_ready or zero) and ir_write.
- Every output not listed for a state is 0; ext_sel=1 unless stated.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_ctrl=ADD, pc_src=00.
  - pc_write=ir_write=mem_ready.
  - Advances to DECODE only when mem_ready=1; otherwise holds.
- DECODE: alu_src_a=0, alu_src_b=11, alu_ctrl=ADD (branch target precompute). Next state by opcode:
  - 0x23 lw / 0x2B sw -> MEMADR
  - 0x00 R-type -> EXEC
  - 0x04 beq -> BRANCH
  - 0x02 j -> JUMP
  - 0x08 addi / 0x0C andi / 0x0D ori -> IEXEC
  - other -> HALT with trap=01
- MEMADR: alu_src_a=1, alu_src_b=10, ADD. Goes to MEMRD (lw) or MEMWR (sw).
- MEMRD: mem_read=1, iord=1. Goes to MEMWB on mem_ready.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Goes to FETCH.
- MEMWR: mem_write=1, iord=1. Goes to FETCH on mem_ready.
- EXEC: alu_src_a=1, alu_src_b=00, alu_ctrl from funct:
  - 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT
  - unknown funct -> HALT, trap=01, no RWB
- RWB: reg_write=1, reg_dst=1, mem_to_reg=0. Goes to FETCH.
- IEXEC: alu_src_a=1, alu_src_b=10.
  - addi -> ADD, ext_sel=1
  - andi -> AND, ext_sel=0
  - ori -> OR, ext_sel=0
  - Goes to IWB; ext_sel is held through IWB.
- IWB: reg_write=1, reg_dst=0. Goes to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_src=01, pc_write=zero. Goes to FETCH.
- JUMP: pc_write=1, pc_src=10. Goes to FETCH.
- HALT: all enables 0; held until reset.
- Timeout:
  - An 8-bit counter clears on entry to FETCH, MEMRD or MEMWR and increments each cycle mem_ready=0 in those states.
  - When the counter reaches TIMEOUT with mem_ready still 0 -> HALT, trap=10.
  - mem_ready=1 in the same cycle as the limit wins (normal advance).
- retired increments by 1 on the last cycle of each instruction: MEMWB, MEMWR&mem_ready, RWB, IWB, BRANCH, JUMP. Wraps modulo 2^CNT_W.
- Cycle counts with zero-wait memory:
  - lw 5
  - sw, R-type, addi/andi/ori 4
  - beq, j 3

Decomposition:
- Package mc_pkg holds:
  - opcode and funct localparams
  - state enum (4-bit)
  - alu_ctrl encoding: ADD=010, SUB=110, AND=000, OR=001, SLT=111
  - alu_src_b and pc_src encodings
- One sub-module, alu_decoder: combinational; maps state class + opcode + funct to alu_ctrl and a funct_valid flag.

Test Plan:
- Reset, then add (op 0, funct 0x20) with mem_ready=1 -> states FETCH,DECODE,EXEC,RWB; reg_write=1, reg_dst=1 in cycle 4; retired=1.
- lw with mem_ready low for 3 cycles in MEMRD -> MEMRD held 4 cycles, MEMWB once, mem_to_reg=1; total 8 cycles.
- beq with zero=1 then zero=0 -> pc_write=1 with pc_src=01 in first BRANCH, pc_write=0 in second; retired counts both.
- andi then addi -> ext_sel=0 in IEXEC/IWB for andi, 1 for addi; alu_ctrl AND then ADD.
- opcode 0x3F; and separately op 0 with funct 0x00 -> HALT, trap=01, no further pc_write until rst_n pulse; retired unchanged.
- mem_ready held 0 in FETCH with TIMEOUT=15 -> trap=10 after 15 stall cycles; rst_n asserted mid-MEMWR -> state RST, mem_write=0 immediately, retired=0.
